// File: rtl/mem_port_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | mem_port_arbiter_pkg : shared encodings and defaults for the arbiter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    localparam int unsigned DEF_WORD_SIZE  = 32;
    localparam int unsigned DEF_MEM_LAT    = 2;
    localparam int unsigned DEF_STARVE_MAX = 3;
    // Wide enough for MEM_LAT and STARVE_MAX up to 15
    localparam int unsigned CNT_W          = 4;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_arb_priority_pick.sv
// +----------------------------------------------------------------------+
// | arb_priority_pick : fixed-priority pick, LS first unless IF starved  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module arb_priority_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic   if_req_i,
    input  logic   ls_req_i,
    input  logic   starved_i,
    output logic   grant_o,
    output owner_e owner_o
);

    always_comb begin
        grant_o = if_req_i | ls_req_i;
        owner_o = OWN_LS;
        if (if_req_i && (!ls_req_i || starved_i)) begin
            owner_o = OWN_IF;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_port_arbiter : shares one memory port between fetch and ld/st    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = DEF_WORD_SIZE,
    parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 if_req_i,
    input  logic [WORD_SIZE-1:0] if_addr_i,
    output logic                 if_done_o,
    output logic [WORD_SIZE-1:0] if_rdata_o,
    input  logic                 ls_req_i,
    input  logic                 ls_we_i,
    input  logic [WORD_SIZE-1:0] ls_addr_i,
    input  logic [WORD_SIZE-1:0] ls_wdata_i,
    output logic                 ls_done_o,
    output logic [WORD_SIZE-1:0] ls_rdata_o,
    output logic [WORD_SIZE-1:0] mem_addr_o,
    output logic [WORD_SIZE-1:0] mem_wdata_o,
    output logic                 mem_re_o,
    output logic                 mem_we_o,
    input  logic [WORD_SIZE-1:0] mem_rdata_i
);

    localparam logic [CNT_W-1:0] c_beat_init  = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_MAX);

    state_e               state_q,    state_d;
    owner_e               owner_q,    owner_d;
    logic [WORD_SIZE-1:0] addr_q,     addr_d;
    logic [WORD_SIZE-1:0] wdata_q,    wdata_d;
    logic                 we_q,       we_d;
    logic [CNT_W-1:0]     beat_q,     beat_d;
    logic [CNT_W-1:0]     starve_q,   starve_d;
    logic [WORD_SIZE-1:0] if_rdata_q, if_rdata_d;
    logic [WORD_SIZE-1:0] ls_rdata_q, ls_rdata_d;

    logic   w_grant;
    owner_e w_owner;

    arb_priority_pick u_pick (
        .if_req_i  (if_req_i),
        .ls_req_i  (ls_req_i),
        .starved_i (starve_q == c_starve_max),
        .grant_o   (w_grant),
        .owner_o   (w_owner)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            beat_q     <= '0;
            starve_q   <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            beat_q     <= beat_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        beat_d     = beat_q;
        starve_d   = starve_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        mem_re_o   = 1'b0;
        mem_we_o   = 1'b0;
        if_done_o  = 1'b0;
        ls_done_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_grant) begin
                    state_d = ST_ACCESS;
                    owner_d = w_owner;
                    beat_d  = c_beat_init;
                    if (w_owner == OWN_IF) begin
                        addr_d   = if_addr_i;
                        we_d     = 1'b0;
                        starve_d = '0;
                    end else begin
                        addr_d  = ls_addr_i;
                        wdata_d = ls_wdata_i;
                        we_d    = ls_we_i;
                        // Only a waiting fetch makes an LS grant count toward starvation
                        if (!if_req_i) begin
                            starve_d = '0;
                        end else if (starve_q != c_starve_max) begin
                            starve_d = starve_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_ACCESS: begin
                mem_re_o = !we_q;
                mem_we_o = we_q && (beat_q == '0);
                beat_d   = beat_q - CNT_W'(1);
                if (beat_q == '0) begin
                    state_d = ST_DONE;
                    beat_d  = '0;
                    if (!we_q) begin
                        if (owner_q == OWN_IF) begin
                            if_rdata_d = mem_rdata_i;
                        end else begin
                            ls_rdata_d = mem_rdata_i;
                        end
                    end
                end
            end
            ST_DONE: begin
                if_done_o = (owner_q == OWN_IF);
                ls_done_o = (owner_q == OWN_LS);
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign ls_rdata_o  = ls_rdata_q;

endmodule

`default_nettype wire
